// File: rtl/datamover_tcdm_lane_splitter_pkg.sv
// datamover_tcdm_lane_splitter_pkg: shared defaults and types for the wide-to-narrow TCDM lane splitter
package datamover_tcdm_lane_splitter_pkg;

   localparam int DEFAULT_MP          = 4;
   localparam int DEFAULT_LANE_DW     = 32;
   localparam int DEFAULT_AW          = 32;
   localparam int DEFAULT_SPLIT_DEPTH = 4;

   // one bit per narrow lane at the default lane count
   typedef logic [DEFAULT_MP-1:0] lane_mask_t;

   // width of a counter that must hold every value from 0 to n inclusive
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/datamover_tcdm_lane_splitter_if.sv
// datamover_tcdm_lane_splitter_if: wide HCI-style request/response bus between datamover and lane splitter
// DATAMOVER_SPLIT_RREADY_EN adds the r_ready back-pressure signal on the response side.
interface datamover_tcdm_lane_splitter_if
   import datamover_tcdm_lane_splitter_pkg::*;
#(
   parameter int MP      = DEFAULT_MP,
   parameter int LANE_DW = DEFAULT_LANE_DW,
   parameter int AW      = DEFAULT_AW
);

   logic                    req;
   logic                    gnt;
   logic [AW-1:0]           add;
   logic                    wen;
   logic [MP*LANE_DW/8-1:0] be;
   logic [MP*LANE_DW-1:0]   data;
   logic [MP*LANE_DW-1:0]   r_data;
   logic                    r_valid;
   logic                    err;
`ifdef DATAMOVER_SPLIT_RREADY_EN
   logic                    r_ready;

   modport master (output req, add, wen, be, data, r_ready, input gnt, r_data, r_valid, err);
   modport slave  (input req, add, wen, be, data, r_ready, output gnt, r_data, r_valid, err);
`else
   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid, err);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid, err);
`endif

endinterface

// File: rtl/datamover_tcdm_lane_splitter_fifo.sv
// datamover_lane_resp_fifo: DEPTH-entry synchronous FIFO; pushes when full and pops when empty are ignored
module datamover_lane_resp_fifo
   import datamover_tcdm_lane_splitter_pkg::*;
#(
   parameter int DW    = DEFAULT_LANE_DW,
   parameter int DEPTH = DEFAULT_SPLIT_DEPTH
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_empty,
   output logic          o_full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = cnt_w(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rp];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= nxt(r_wp);
         if (w_pop)  r_rp <= nxt(r_rp);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   // storage carries no reset; validity comes from the occupancy count
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

endmodule

// File: rtl/datamover_tcdm_lane_splitter.sv
// datamover_tcdm_lane_splitter: splits a wide TCDM request into MP narrow lanes and reassembles their responses
// Optional macro DATAMOVER_SPLIT_RREADY_EN: response back-pressure through wide.r_ready.
module datamover_tcdm_lane_splitter
   import datamover_tcdm_lane_splitter_pkg::*;
#(
   parameter int MP      = DEFAULT_MP,
   parameter int LANE_DW = DEFAULT_LANE_DW,
   parameter int AW      = DEFAULT_AW,
   parameter int DEPTH   = DEFAULT_SPLIT_DEPTH
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   datamover_tcdm_lane_splitter_if.slave    wide,
   output logic [MP-1:0]                    lane_req_o,
   input  logic [MP-1:0]                    lane_gnt_i,
   output logic [MP-1:0][AW-1:0]            lane_add_o,
   output logic [MP-1:0]                    lane_wen_o,
   output logic [MP-1:0][LANE_DW/8-1:0]     lane_be_o,
   output logic [MP-1:0][LANE_DW-1:0]       lane_data_o,
   input  logic [MP-1:0][LANE_DW-1:0]       lane_r_data_i,
   input  logic [MP-1:0]                    lane_r_valid_i
);

   localparam int BW = LANE_DW / 8;
   localparam int CW = cnt_w(DEPTH);

   logic [MP-1:0]              r_done;
   logic [MP-1:0][CW-1:0]      r_pend;
   logic [CW-1:0]              r_out;
   logic                       r_rst_d, r_err;
   logic [MP-1:0]              w_skip, w_lane_gnt, w_accept, w_empty, w_lfull, w_hmask, w_pop_lane;
   logic [MP-1:0][LANE_DW-1:0] w_head;
   logic                       w_run, w_full, w_q_empty, w_q_full, w_complete, w_pop;

   // requests are held off in the reset cycle and the one after it
   assign w_run      = ~rst_i & ~r_rst_d;
   assign w_full     = (r_out == CW'(DEPTH));
   assign lane_req_o = {MP{w_run & wide.req & ~w_full}} & ~r_done & ~w_skip;
   assign w_lane_gnt = lane_req_o & lane_gnt_i;
   assign wide.gnt   = w_run & wide.req & ~w_full & (&(r_done | w_lane_gnt | w_skip));
   assign lane_wen_o = {MP{~rst_i & wide.wen}};

   // head transaction completes once every lane it expects has a response queued
   assign w_complete   = ~rst_i & ~w_q_empty & (&(~w_hmask | ~w_empty));
   assign wide.r_valid = w_complete;
   assign wide.err     = r_err;
`ifdef DATAMOVER_SPLIT_RREADY_EN
   assign w_pop = w_complete & wide.r_ready;
`else
   assign w_pop = w_complete;
`endif
   assign w_pop_lane = {MP{w_pop}} & w_hmask;

   // per-lane slicing of the wide request and reassembly of the wide response
   always_comb begin
      for (int i = 0; i < MP; i++) begin
         lane_add_o[i]  = rst_i ? '0 : wide.add + AW'(i * BW);
         lane_be_o[i]   = rst_i ? '0 : wide.be[i*BW +: BW];
         lane_data_o[i] = rst_i ? '0 : wide.data[i*LANE_DW +: LANE_DW];
         w_skip[i]      = ~wide.wen & ~|wide.be[i*BW +: BW];
         w_accept[i]    = lane_r_valid_i[i] & (r_pend[i] != '0) & ~w_lfull[i];
         wide.r_data[i*LANE_DW +: LANE_DW] = (w_complete & w_hmask[i]) ? w_head[i] : '0;
      end
   end

   // grant tracking, outstanding count and reset-release delay
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_done  <= '0;
         r_out   <= '0;
         r_rst_d <= 1'b1;
      end else begin
         r_done  <= wide.gnt ? '0 : r_done | w_lane_gnt;
         r_out   <= r_out + CW'(wide.gnt) - CW'(w_pop);
         r_rst_d <= 1'b0;
      end
   end

   // responses owed per lane; a response with nothing owed or no room is dropped and flagged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend <= '0;
         r_err  <= 1'b0;
      end else begin
         for (int i = 0; i < MP; i++) r_pend[i] <= r_pend[i] + CW'(w_lane_gnt[i]) - CW'(w_accept[i]);
         r_err <= |(lane_r_valid_i & ~w_accept);
      end
   end

   for (genvar g = 0; g < MP; g++) begin : g_lane
      datamover_lane_resp_fifo #(.DW(LANE_DW), .DEPTH(DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .i_push  (w_accept[g]),
         .i_pop   (w_pop_lane[g]),
         .i_data  (lane_r_data_i[g]),
         .o_data  (w_head[g]),
         .o_empty (w_empty[g]),
         .o_full  (w_lfull[g])
      );
   end

   datamover_lane_resp_fifo #(.DW(MP), .DEPTH(DEPTH)) u_mask_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (wide.gnt),
      .i_pop   (w_pop),
      .i_data  (~w_skip),
      .o_data  (w_hmask),
      .o_empty (w_q_empty),
      .o_full  (w_q_full)
   );

`ifndef SYNTHESIS
   a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      wide.req && !wide.gnt |=> wide.req && $stable(wide.add) && $stable(wide.wen) && $stable(wide.be) && $stable(wide.data));
   a_out_max: assert property (@(posedge clk_i) disable iff (rst_i) r_out <= CW'(DEPTH));
   a_q_track: assert property (@(posedge clk_i) disable iff (rst_i) w_q_full == w_full);
`ifdef DATAMOVER_SPLIT_RREADY_EN
   a_r_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      wide.r_valid && !wide.r_ready |=> wide.r_valid && $stable(wide.r_data));
`endif
`endif

endmodule
